// File: rtl/tetris_pkg.sv
// Shared definitions between the game sequencer and the board row engine.
package tetris_pkg;

   localparam int ROWS_DEF = 22;
   localparam int COLS_DEF = 10;

   typedef enum logic [2:0] {
      GS_CHECK = 3'b000,
      GS_MOVE  = 3'b001,
      GS_WRITE = 3'b010,
      GS_SHIFT = 3'b011,
      GS_ADD   = 3'b100
   } game_state_e;

   typedef enum logic [1:0] {
      OP_IDLE,
      OP_SCAN,
      OP_WRITE,
      OP_SHIFT
   } board_op_e;

   // Index of the highest set bit, which is the lowest full row on screen.
   function automatic logic [4:0] highest_set(input logic [31:0] vec);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (vec[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/row_full_detect.sv
// Row helper: full-row AND-reduce and placement of one 4-cell mask row,
// clipped at the right edge of the playfield.
module row_full_detect
   import tetris_pkg::*;
#(
   parameter int COLS = COLS_DEF
) (
   input  logic [COLS-1:0] row_data_i,
   input  logic [3:0]      mask_nib_i,
   input  logic [3:0]      col_i,
   output logic            full_o,
   output logic [COLS-1:0] placed_o
);

   logic [4:0] offset;

   assign full_o = &row_data_i;

   // Board column c takes mask column c-col_i when that lands inside 0..3.
   always_comb begin
      placed_o = '0;
      offset   = '0;
      for (int c = 0; c < COLS; c++) begin
         offset = 5'(c) - {1'b0, col_i};
         if ((5'(c) >= {1'b0, col_i}) && (offset < 5'd4)) begin
            placed_o[c] = mask_nib_i[offset[1:0]];
         end
      end
   end

endmodule

// File: rtl/board_row_engine.sv
// Playfield bitmap owner: scans for full rows, merges landed pieces and
// collapses the lowest full row, as selected by the sequencer state code.
module board_row_engine
   import tetris_pkg::*;
#(
   parameter int ROWS       = ROWS_DEF,
   parameter int COLS       = COLS_DEF,
   parameter int SPAWN_ROWS = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [2:0]      state_code,
   input  logic [4:0]      piece_row,
   input  logic [3:0]      piece_col,
   input  logic [15:0]     piece_mask,
   input  logic [4:0]      rd_row,
   output logic [COLS-1:0] rd_data,
   output logic [ROWS-1:0] shift,
   output logic            busy,
   output logic            op_done,
   output logic            overlap,
   output logic            spawn_blocked
);

   localparam logic [4:0] ROWS5 = 5'(ROWS);
   localparam logic [5:0] ROWS6 = 6'(ROWS);

   board_op_e                  state_q, state_d;
   logic [4:0]                 idx_q, idx_d;
   logic [2:0]                 last_code_q, last_code_d;
   logic [ROWS-1:0][COLS-1:0]  board_q, board_d;
   logic [ROWS-1:0]            scan_vec_q, scan_vec_d;
   logic [ROWS-1:0]            shift_q, shift_d;
   logic                       op_done_q, op_done_d;
   logic                       overlap_q, overlap_d;
   logic [COLS-1:0]            rd_data_q, rd_data_d;
   logic [4:0]                 p_row_q, p_row_d;
   logic [3:0]                 p_col_q, p_col_d;
   logic [15:0]                p_mask_q, p_mask_d;
   logic [4:0]                 tgt_q, tgt_d;

   logic [5:0]      wr_row;
   logic            wr_valid;
   logic [4:0]      sel_row;
   logic [COLS-1:0] sel_data;
   logic [COLS-1:0] placed;
   logic            sel_full;
   logic [3:0]      mask_nib;

   // The write target can run past the bottom; keep the extra bit for clipping.
   assign wr_row   = {1'b0, p_row_q} + {4'b0, idx_q[1:0]};
   assign wr_valid = (wr_row < ROWS6);
   assign sel_row  = (state_q == OP_WRITE) ? wr_row[4:0] : idx_q;
   assign sel_data = (sel_row < ROWS5) ? board_q[sel_row] : '0;
   assign mask_nib = p_mask_q[{idx_q[1:0], 2'b00} +: 4];

   row_full_detect #(
      .COLS (COLS)
   ) u_row_full_detect (
      .row_data_i (sel_data),
      .mask_nib_i (mask_nib),
      .col_i      (p_col_q),
      .full_o     (sel_full),
      .placed_o   (placed)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      last_code_d = last_code_q;
      board_d     = board_q;
      scan_vec_d  = scan_vec_q;
      shift_d     = shift_q;
      op_done_d   = 1'b0;
      overlap_d   = overlap_q;
      p_row_d     = p_row_q;
      p_col_d     = p_col_q;
      p_mask_d    = p_mask_q;
      tgt_d       = tgt_q;
      rd_data_d   = (rd_row < ROWS5) ? board_q[rd_row] : '0;

      case (state_q)
         OP_IDLE: begin
            if (state_code != last_code_q) begin
               last_code_d = state_code;
               idx_d       = '0;
               case (state_code)
                  GS_CHECK: state_d = OP_SCAN;
                  GS_WRITE: begin
                     state_d   = OP_WRITE;
                     overlap_d = 1'b0;
                     p_row_d   = piece_row;
                     p_col_d   = piece_col;
                     p_mask_d  = piece_mask;
                  end
                  GS_SHIFT: begin
                     if (shift_q == '0) begin
                        op_done_d = 1'b1;
                     end else begin
                        state_d = OP_SHIFT;
                        tgt_d   = highest_set(32'(shift_q));
                        idx_d   = tgt_d;
                     end
                  end
                  default: op_done_d = 1'b1;
               endcase
            end
         end

         OP_SCAN: begin
            scan_vec_d[idx_q] = sel_full;
            if (idx_q == ROWS5 - 5'd1) begin
               shift_d   = scan_vec_d;
               state_d   = OP_IDLE;
               op_done_d = 1'b1;
            end else begin
               idx_d = idx_q + 5'd1;
            end
         end

         OP_WRITE: begin
            if (wr_valid) begin
               board_d[wr_row[4:0]] = board_q[wr_row[4:0]] | placed;
               if ((placed & sel_data) != '0) overlap_d = 1'b1;
            end
            if (idx_q[1:0] == 2'd3) begin
               state_d   = OP_IDLE;
               op_done_d = 1'b1;
            end else begin
               idx_d = idx_q + 5'd1;
            end
         end

         OP_SHIFT: begin
            if (idx_q != 5'd0) begin
               board_d[idx_q] = board_q[idx_q - 5'd1];
               idx_d          = idx_q - 5'd1;
            end else begin
               board_d[0]     = '0;
               shift_d[tgt_q] = 1'b0;
               state_d        = OP_IDLE;
               op_done_d      = 1'b1;
            end
         end

         default: state_d = OP_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= OP_IDLE;
         idx_q       <= '0;
         last_code_q <= 3'b111;
         board_q     <= '0;
         scan_vec_q  <= '0;
         shift_q     <= '0;
         op_done_q   <= 1'b0;
         overlap_q   <= 1'b0;
         rd_data_q   <= '0;
         p_row_q     <= '0;
         p_col_q     <= '0;
         p_mask_q    <= '0;
         tgt_q       <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         last_code_q <= last_code_d;
         board_q     <= board_d;
         scan_vec_q  <= scan_vec_d;
         shift_q     <= shift_d;
         op_done_q   <= op_done_d;
         overlap_q   <= overlap_d;
         rd_data_q   <= rd_data_d;
         p_row_q     <= p_row_d;
         p_col_q     <= p_col_d;
         p_mask_q    <= p_mask_d;
         tgt_q       <= tgt_d;
      end
   end

   assign rd_data       = rd_data_q;
   assign shift         = shift_q;
   assign busy          = (state_q != OP_IDLE);
   assign op_done       = op_done_q;
   assign overlap       = overlap_q;
   assign spawn_blocked = |board_q[SPAWN_ROWS-1:0];

endmodule

// File: tb/tb_board_row_engine.sv
// Bench for board_row_engine: directed scenarios plus random operations,
// all checked against a cell-level model of the playfield.
module tb_board_row_engine;

   localparam int ROWS  = 22;
   localparam int COLS  = 10;
   localparam int SPAWN = 2;

   logic            clk;
   logic            reset;
   logic [2:0]      state_code;
   logic [4:0]      piece_row;
   logic [3:0]      piece_col;
   logic [15:0]     piece_mask;
   logic [4:0]      rd_row;
   logic [COLS-1:0] rd_data;
   logic [ROWS-1:0] shift;
   logic            busy;
   logic            op_done;
   logic            overlap;
   logic            spawn_blocked;

   logic [COLS-1:0] mBoard [ROWS];
   logic [ROWS-1:0] mShift;
   logic            mOverlap;
   logic [2:0]      mLast;

   int nCompared;
   int nMismatched;

   board_row_engine #(
      .ROWS       (ROWS),
      .COLS       (COLS),
      .SPAWN_ROWS (SPAWN)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .state_code    (state_code),
      .piece_row     (piece_row),
      .piece_col     (piece_col),
      .piece_mask    (piece_mask),
      .rd_row        (rd_row),
      .rd_data       (rd_data),
      .shift         (shift),
      .busy          (busy),
      .op_done       (op_done),
      .overlap       (overlap),
      .spawn_blocked (spawn_blocked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
      end
   endtask

   task automatic modelClear();
      for (int r = 0; r < ROWS; r++) mBoard[r] = '0;
      mShift   = '0;
      mOverlap = 1'b0;
      mLast    = 3'b111;
   endtask

   function automatic logic modelSpawn();
      logic s;
      s = 1'b0;
      for (int r = 0; r < SPAWN; r++) s = s | (|mBoard[r]);
      return s;
   endfunction

   // Applies the board rules for one launched code; returns cycles until op_done.
   task automatic modelLaunch(input logic [2:0] code, output int lat);
      int k, rr, cc;
      mLast = code;
      lat   = 1;
      case (code)
         3'b000: begin
            for (int r = 0; r < ROWS; r++) mShift[r] = (mBoard[r] == {COLS{1'b1}});
            lat = ROWS + 1;
         end
         3'b010: begin
            mOverlap = 1'b0;
            for (int kr = 0; kr < 4; kr++) begin
               for (int c = 0; c < 4; c++) begin
                  rr = int'(piece_row) + kr;
                  cc = int'(piece_col) + c;
                  if (piece_mask[kr*4+c] && rr < ROWS && cc < COLS) begin
                     if (mBoard[rr][cc]) mOverlap = 1'b1;
                     mBoard[rr][cc] = 1'b1;
                  end
               end
            end
            lat = 5;
         end
         3'b011: begin
            if (mShift != '0) begin
               k = 0;
               for (int r = 0; r < ROWS; r++) if (mShift[r]) k = r;
               for (int r = k; r > 0; r--) mBoard[r] = mBoard[r-1];
               mBoard[0] = '0;
               mShift[k] = 1'b0;
               lat = k + 2;
            end
         end
         default: lat = 1;
      endcase
   endtask

   task automatic applyStimulus(input logic [2:0] code);
      int expLat, n;
      logic seenDone, busyOk;
      modelLaunch(code, expLat);
      state_code = code;
      n = 0;
      seenDone = 1'b0;
      busyOk = 1'b1;
      while (!seenDone && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         // Piece inputs must be held internally from launch on.
         if (n == 1) begin
            piece_row  = 5'($urandom);
            piece_col  = 4'($urandom);
            piece_mask = 16'($urandom);
         end
         if (op_done) seenDone = 1'b1;
         else if (!busy) busyOk = 1'b0;
      end
      checkOutput("done_seen", 32'(seenDone), 32'd1);
      checkOutput("latency", 32'(n), 32'(expLat));
      if (expLat > 1) checkOutput("busy_hold", 32'(busyOk), 32'd1);
      checkOutput("busy_at_done", 32'(busy), 32'd0);
      checkOutput("shift", 32'(shift), 32'(mShift));
      checkOutput("overlap", 32'(overlap), 32'(mOverlap));
      checkOutput("spawn", 32'(spawn_blocked), 32'(modelSpawn()));
      @(posedge clk);
      #1;
      checkOutput("done_pulse", 32'(op_done), 32'd0);
   endtask

   task automatic doWrite(input logic [4:0] row, input logic [3:0] col, input logic [15:0] mask);
      if (mLast == 3'b010) applyStimulus(3'b001);
      piece_row  = row;
      piece_col  = col;
      piece_mask = mask;
      applyStimulus(3'b010);
   endtask

   task automatic readRow(input int r, output logic [COLS-1:0] val);
      rd_row = 5'(r);
      @(posedge clk);
      #1;
      val = rd_data;
   endtask

   task automatic sweepBoard();
      logic [COLS-1:0] v, e;
      for (int r = 0; r < ROWS + 2; r++) begin
         readRow(r, v);
         e = (r < ROWS) ? mBoard[r] : '0;
         checkOutput($sformatf("rd_row%0d", r), 32'(v), 32'(e));
      end
   endtask

   logic [COLS-1:0] rv;
   logic [2:0]      pick [8];
   logic [2:0]      code;
   int              pulses, firstAt, lat, lateDone;

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      reset       = 1'b0;
      state_code  = 3'b111;
      piece_row   = '0;
      piece_col   = '0;
      piece_mask  = '0;
      rd_row      = '0;
      modelClear();
      pick = '{3'b000, 3'b001, 3'b010, 3'b010, 3'b010, 3'b011, 3'b100, 3'b010};

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(op_done), 32'd0);
      checkOutput("rst_shift", 32'(shift), 32'd0);
      checkOutput("rst_overlap", 32'(overlap), 32'd0);
      checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
      checkOutput("rst_spawn", 32'(spawn_blocked), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Empty board scan.
      applyStimulus(3'b000);
      checkOutput("empty_shift", 32'(shift), 32'h0);
      sweepBoard();

      // Fill row 21 from three pieces, seed row 20, then scan and collapse.
      doWrite(5'd21, 4'd0, 16'h000F);
      doWrite(5'd21, 4'd4, 16'h000F);
      doWrite(5'd21, 4'd8, 16'h0003);
      doWrite(5'd20, 4'd0, 16'h0001);
      readRow(21, rv);
      checkOutput("row21_full", 32'(rv), 32'h3FF);
      applyStimulus(3'b000);
      checkOutput("shift_row21", 32'(shift), 32'h200000);
      applyStimulus(3'b011);
      readRow(21, rv);
      checkOutput("row21_after", 32'(rv), 32'h001);
      readRow(20, rv);
      checkOutput("row20_after", 32'(rv), 32'h000);
      checkOutput("shift_cleared", 32'(shift), 32'h0);
      applyStimulus(3'b000);
      checkOutput("rescan_shift", 32'(shift), 32'h0);

      // Spawn area, overlap, and edge clipping.
      doWrite(5'd0, 4'd3, 16'h0033);
      checkOutput("spawn_set", 32'(spawn_blocked), 32'd1);
      checkOutput("overlap_clear", 32'(overlap), 32'd0);
      doWrite(5'd0, 4'd3, 16'h0033);
      checkOutput("overlap_set", 32'(overlap), 32'd1);
      doWrite(5'd5, 4'd9, 16'h000F);
      readRow(5, rv);
      checkOutput("col_clip", 32'(rv), 32'h200);
      doWrite(5'd20, 4'd0, 16'hFFFF);
      sweepBoard();

      // Code toggled during a scan is ignored; no second scan follows.
      if (mLast == 3'b000) applyStimulus(3'b001);
      modelLaunch(3'b000, lat);
      state_code = 3'b000;
      pulses  = 0;
      firstAt = 0;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk);
         #1;
         if (op_done) begin
            pulses++;
            if (firstAt == 0) firstAt = n;
         end
         if (n == 5) state_code = 3'b001;
         if (n == 8) state_code = 3'b000;
      end
      checkOutput("toggle_pulses", 32'(pulses), 32'd1);
      checkOutput("toggle_latency", 32'(firstAt), 32'(lat));
      checkOutput("toggle_shift", 32'(shift), 32'(mShift));
      checkOutput("toggle_idle", 32'(busy), 32'd0);

      // Random operations against the model.
      for (int i = 0; i < 30; i++) begin
         do code = pick[$urandom_range(0, 7)]; while (code == mLast);
         piece_row  = 5'($urandom_range(14, 23));
         piece_col  = 4'($urandom_range(0, 11));
         piece_mask = 16'($urandom);
         applyStimulus(code);
         sweepBoard();
      end

      // Reset in the middle of a collapse.
      doWrite(5'd21, 4'd0, 16'h000F);
      doWrite(5'd21, 4'd4, 16'h000F);
      doWrite(5'd21, 4'd8, 16'h0003);
      if (mLast == 3'b000) applyStimulus(3'b001);
      applyStimulus(3'b000);
      state_code = 3'b011;
      for (int n = 0; n < 5; n++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("busy_mid_shift", 32'(busy), 32'd1);
      reset      = 1'b0;
      state_code = 3'b111;
      #1;
      modelClear();
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_shift", 32'(shift), 32'd0);
      checkOutput("abort_done", 32'(op_done), 32'd0);
      checkOutput("abort_rd_data", 32'(rd_data), 32'd0);
      checkOutput("abort_spawn", 32'(spawn_blocked), 32'd0);
      lateDone = 0;
      for (int n = 0; n < 4; n++) begin
         @(posedge clk);
         #1;
         if (op_done) lateDone++;
      end
      @(negedge clk);
      reset = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk);
         #1;
         if (op_done) lateDone++;
      end
      checkOutput("abort_no_done", 32'(lateDone), 32'd0);
      sweepBoard();
      applyStimulus(3'b000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
